mem_arbiter: RTL

//  Shares the single memory port of the core between instruction fetch (IFU) and load/store (LSU).

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares the core's single memory port between instruction fetch and load/store.
// One transaction in flight at a time; a watchdog turns a hung access into an error response.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PRIO_LSU = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_W-1:0]     ifu_rsp_data,
  output logic                  ifu_rsp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_W-1:0]     lsu_rsp_data,
  output logic                  lsu_rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic                  busy
);
  // state | meaning
  // IDLE  | no transaction; winner picked combinationally and accepted
  // REQ   | latched request presented to memory
  // RESP  | waiting for the memory response
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_lsu_q, owner_lsu_d;
  logic                last_lsu_q, last_lsu_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic                grant_lsu;
  logic                timeout;
  logic                rsp_fire;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_word;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      grant_lsu = (PRIO_LSU != 0) ? 1'b1 : !last_lsu_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_lsu_d   = owner_lsu_q;
    last_lsu_d    = last_lsu_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    rsp_fire      = 1'b0;
    rsp_err       = 1'b0;
    rsp_word      = '0;
    case (state_q)
      IDLE: begin
        if (!rst && (ifu_req_valid || lsu_req_valid)) begin
          if (grant_lsu) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_addr;
            wen_d         = lsu_wen;
            wdata_d       = lsu_wdata;
            wmask_d       = lsu_wmask;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wmask_d       = '0;
          end
          owner_lsu_d = grant_lsu;
          last_lsu_d  = grant_lsu;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        if (timeout) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end else if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        // a real response on the watchdog's last cycle still wins
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_word = wen_q ? '0 : mem_rsp_data;
          state_d  = IDLE;
        end else if (timeout) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      last_lsu_q  <= 1'b1;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      last_lsu_q  <= last_lsu_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

  assign ifu_rsp_valid = rsp_fire && !owner_lsu_q;
  assign lsu_rsp_valid = rsp_fire && owner_lsu_q;
  assign ifu_rsp_data  = ifu_rsp_valid ? rsp_word : '0;
  assign lsu_rsp_data  = lsu_rsp_valid ? rsp_word : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && rsp_err;
  assign lsu_rsp_err   = lsu_rsp_valid && rsp_err;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != IDLE);

endmodule
